adder_arbiter_ctrl: RTL and testbench
=====================================

Name: adder_arbiter_ctrl

Overview:
Two-requester arbiter and sequencer for one shared registered binary adder unit, such as the 8-bit cascaded adder.
Grants one requester at a time and latches that requester's operands. Drives the unit's EN/MODO/A/B/Cin for one issue cycle, waits the unit latency, then captures Q/RCO and returns them with a one-cycle ACK.
Sits between the lab's operand sources and the single adder instance.

Parameters:
WIDTH, 8, operand/result width; must match the shared unit.
UNIT_LAT, 1, cycles from the U_EN issue edge until U_Q/U_RCO are valid; legal range 1..15.

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  synchronous reset, active-high
REQ0  input  1  requester 0 request; level, held until ACK0
A0  input  WIDTH  requester 0 operand A
B0  input  WIDTH  requester 0 operand B
CIN0  input  1  requester 0 carry-in
MODO0  input  2  requester 0 unit mode
ACK0  output  1  one-cycle pulse; Q0/RCO0 valid in this cycle
Q0  output  WIDTH  result to requester 0 (registered)
RCO0  output  1  carry-out to requester 0 (registered)
REQ1, A1, B1, CIN1, MODO1, ACK1, Q1, RCO1  same as above, for requester 1
GNT  output  2  one-hot owner of the unit; 00 when idle
U_EN  output  1  unit enable; high only in ISSUE
U_MODO  output  2  mode to unit
U_A  output  WIDTH  operand A to unit
U_B  output  WIDTH  operand B to unit
U_CIN  output  1  carry-in to unit
U_Q  input  WIDTH  unit result
U_RCO  input  1  unit carry-out

Behaviour:
- Reset (RESET high at an edge):
  - state=IDLE; every output is 0 (ACKx, Qx, RCOx, GNT, U_*).
  - wait counter=0; round-robin pointer last=1, so requester 0 wins first.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ high: grant it.
  - Both REQ high: grant the requester not equal to last.
  - On grant: latch that requester's A/B/CIN/MODO into the U_A/U_B/U_CIN/U_MODO registers; set GNT; go to ISSUE.
- ISSUE (1 cycle): U_EN=1; counter loaded with UNIT_LAT; go to WAIT.
- WAIT (exactly UNIT_LAT cycles):
  - U_EN=0; counter decrements.
  - At the end of the final WAIT cycle, U_Q/U_RCO are captured into the granted requester's Qx/RCOx.
  - Go to RESP.
- RESP (1 cycle):
  - ACKx=1 for the granted requester only; last<=granted.
  - At the end of the cycle: GNT<=00; go to IDLE.
- Latency: REQ seen in IDLE at cycle 0 -> U_EN at cycle 1 -> ACK at cycle 2+UNIT_LAT. Throughput: one operation per 3+UNIT_LAT cycles.
- Output holding:
  - U_A/U_B/U_CIN/U_MODO hold the latched values from grant until the next grant.
  - Qx/RCOx hold their last result until that requester's next capture.
  - The other requester's Qx/RCOx are never disturbed.
- Requester rules:
  - Operands are sampled only at the grant edge; later changes to Ax/Bx are ignored.
  - The requester drops REQ on the edge that ends its ACK cycle. If REQ is still high in IDLE, that is a new operation.
  - REQ dropped after grant: the operation still completes and ACK still pulses.
- Arithmetic: the controller performs no arithmetic. Widths pass straight through; carry comes only from U_RCO.
- RESET mid-operation (any state): abort; no ACK; all outputs 0 on the next cycle; pointer reset.
- Invalid UNIT_LAT=0: treated as 1.

Optional Feature:
Macro ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both request. The last pointer is not implemented; requester 1 can starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset: hold RESET high 2 cycles with both REQ high -> all outputs 0, no U_EN, GNT=00. Release -> requester 0 granted first.
- Single op, UNIT_LAT=1, bench model Q<=A+B+Cin when EN, MODO0=00, A0=8'h3C B0=8'h05 CIN0=0:
  - U_EN high at cycle 1 only, U_A=8'h3C.
  - ACK0 at cycle 3 with Q0=8'h41, RCO0=0; GNT=01 during cycles 1-3.
- Carry, requester 1: A1=8'hFF B1=8'h01 CIN1=1 -> ACK1 with Q1=8'h01, RCO1=1; Q0 unchanged.
- Contention: REQ0 and REQ1 held, each re-asserted immediately after its ACK -> grants alternate 0,1,0,1; ACKs at cycles 3,7,11,15 (UNIT_LAT=1).
- Reset mid-operation: RESET at a WAIT cycle -> no ACK, outputs 0 next cycle; with both requesting afterwards, requester 0 wins.
- With ADDER_ARB_FIXED_PRIO_EN defined, both REQ held continuously -> only ACK0 pulses, every 4 cycles; ACK1 never pulses.

Source files
------------

// File: rtl/adder_arbiter_ctrl.sv
// Two-requester arbiter/sequencer for one shared registered adder unit.
// Optional ADDER_ARB_FIXED_PRIO_EN: fixed priority to requester 0 instead of round-robin.
module adder_arbiter_ctrl #(
   parameter int WIDTH    = 8,
   parameter int UNIT_LAT = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REQ0,
   input  logic [WIDTH-1:0] A0,
   input  logic [WIDTH-1:0] B0,
   input  logic             CIN0,
   input  logic [1:0]       MODO0,
   output logic             ACK0,
   output logic [WIDTH-1:0] Q0,
   output logic             RCO0,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] B1,
   input  logic             CIN1,
   input  logic [1:0]       MODO1,
   output logic             ACK1,
   output logic [WIDTH-1:0] Q1,
   output logic             RCO1,
   output logic [1:0]       GNT,
   output logic             U_EN,
   output logic [1:0]       U_MODO,
   output logic [WIDTH-1:0] U_A,
   output logic [WIDTH-1:0] U_B,
   output logic             U_CIN,
   input  logic [WIDTH-1:0] U_Q,
   input  logic             U_RCO
);

   // A latency of 0 would skip the capture cycle entirely, so clamp to 1.
   localparam int         LAT  = (UNIT_LAT < 1) ? 1 : UNIT_LAT;
   localparam logic [3:0] LAT4 = 4'(LAT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic [1:0] pick;
`ifndef ADDER_ARB_FIXED_PRIO_EN
   logic       last;
`endif

   always_comb begin
      pick = 2'b00;
      if (REQ0 && REQ1) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
         pick = 2'b01;
`else
         pick = last ? 2'b01 : 2'b10;
`endif
      end else if (REQ0) begin
         pick = 2'b01;
      end else if (REQ1) begin
         pick = 2'b10;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (pick != 2'b00) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (cnt <= 4'd1) state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         GNT    <= 2'b00;
         U_MODO <= 2'b00;
         U_A    <= '0;
         U_B    <= '0;
         U_CIN  <= 1'b0;
         Q0     <= '0;
         RCO0   <= 1'b0;
         Q1     <= '0;
         RCO1   <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
         last   <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (pick != 2'b00) begin
               GNT    <= pick;
               U_A    <= pick[1] ? A1    : A0;
               U_B    <= pick[1] ? B1    : B0;
               U_CIN  <= pick[1] ? CIN1  : CIN0;
               U_MODO <= pick[1] ? MODO1 : MODO0;
            end
            ISSUE: cnt <= LAT4;
            WAIT: begin
               cnt <= cnt - 4'd1;
               // Final wait cycle: unit output is valid now, route it to the owner only.
               if (cnt <= 4'd1) begin
                  if (GNT[0]) begin
                     Q0   <= U_Q;
                     RCO0 <= U_RCO;
                  end
                  if (GNT[1]) begin
                     Q1   <= U_Q;
                     RCO1 <= U_RCO;
                  end
               end
            end
            RESP: begin
               GNT  <= 2'b00;
`ifndef ADDER_ARB_FIXED_PRIO_EN
               last <= GNT[1];
`endif
            end
            default: ;
         endcase
      end
   end

   assign U_EN = (state == ISSUE);
   assign ACK0 = (state == RESP) && GNT[0];
   assign ACK1 = (state == RESP) && GNT[1];

endmodule

// File: tb/tb_adder_arbiter_ctrl.sv
// Directed bench for adder_arbiter_ctrl with a one-cycle registered adder model on the unit side.
module tb_adder_arbiter_ctrl;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         REQ0, REQ1, CIN0, CIN1;
   logic [W-1:0] A0, B0, A1, B1;
   logic [1:0]   MODO0, MODO1;
   logic         ACK0, ACK1, RCO0, RCO1;
   logic [W-1:0] Q0, Q1;
   logic [1:0]   GNT, U_MODO;
   logic         U_EN, U_CIN, U_RCO;
   logic [W-1:0] U_A, U_B, U_Q;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   adder_arbiter_ctrl #(.WIDTH(W), .UNIT_LAT(1)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(REQ0), .A0(A0), .B0(B0), .CIN0(CIN0), .MODO0(MODO0),
      .ACK0(ACK0), .Q0(Q0), .RCO0(RCO0),
      .REQ1(REQ1), .A1(A1), .B1(B1), .CIN1(CIN1), .MODO1(MODO1),
      .ACK1(ACK1), .Q1(Q1), .RCO1(RCO1),
      .GNT(GNT), .U_EN(U_EN), .U_MODO(U_MODO), .U_A(U_A), .U_B(U_B),
      .U_CIN(U_CIN), .U_Q(U_Q), .U_RCO(U_RCO)
   );

   // Shared unit model: registered add, result valid one cycle after EN.
   always_ff @(posedge CLK) begin
      if (RESET) {U_RCO, U_Q} <= '0;
      else if (U_EN) {U_RCO, U_Q} <= {1'b0, U_A} + {1'b0, U_B} + {8'd0, U_CIN};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic e0, e1;
      RESET = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
      A0 = 8'h3C; B0 = 8'h05; CIN0 = 1'b0; MODO0 = 2'b00;
      A1 = 8'hFF; B1 = 8'h01; CIN1 = 1'b1; MODO1 = 2'b00;

      // Reset held two edges with both requesting
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_gnt", 32'(GNT), 32'h0);
         chk("rst_uen", 32'(U_EN), 32'h0);
         chk("rst_ack", 32'({ACK1, ACK0}), 32'h0);
         chk("rst_q", 32'({Q1, Q0, RCO1, RCO0}), 32'h0);
         chk("rst_ua", 32'({U_A, U_B, U_CIN, U_MODO}), 32'h0);
      end
      RESET = 1'b0;                       // cycle 0: IDLE, both requesting

      step();                             // cycle 1: ISSUE, requester 0 wins
      chk("c1_gnt", 32'(GNT), 32'h1);
      chk("c1_uen", 32'(U_EN), 32'h1);
      chk("c1_ua", 32'(U_A), 32'h3C);
      chk("c1_ub", 32'(U_B), 32'h05);
      A0 = 8'h00;                         // post-grant change must be ignored
      step();                             // cycle 2: WAIT
      chk("c2_uen", 32'(U_EN), 32'h0);
      chk("c2_gnt", 32'(GNT), 32'h1);
      chk("c2_ack", 32'({ACK1, ACK0}), 32'h0);
      step();                             // cycle 3: RESP
      chk("c3_ack0", 32'(ACK0), 32'h1);
      chk("c3_ack1", 32'(ACK1), 32'h0);
      chk("c3_q0", 32'(Q0), 32'h41);
      chk("c3_rco0", 32'(RCO0), 32'h0);
      chk("c3_gnt", 32'(GNT), 32'h1);
      REQ0 = 1'b0;
      step();                             // cycle 4: IDLE, only requester 1
      chk("c4_gnt", 32'(GNT), 32'h0);
      step();                             // cycle 5: ISSUE for requester 1
      chk("c5_gnt", 32'(GNT), 32'h2);
      chk("c5_uen", 32'(U_EN), 32'h1);
      chk("c5_ua", 32'({U_A, U_CIN}), {23'd0, 8'hFF, 1'b1});
      step();                             // cycle 6: WAIT
      step();                             // cycle 7: RESP
      chk("c7_ack1", 32'(ACK1), 32'h1);
      chk("c7_ack0", 32'(ACK0), 32'h0);
      chk("c7_q1", 32'(Q1), 32'h01);
      chk("c7_rco1", 32'(RCO1), 32'h1);
      chk("c7_q0_held", 32'({Q0, RCO0}), {23'd0, 8'h41, 1'b0});
      REQ1 = 1'b0;
      step();                             // cycle 8: IDLE, nobody requesting
      chk("c8_idle", 32'({GNT, U_EN, ACK1, ACK0}), 32'h0);
      chk("c8_ua_held", 32'(U_A), 32'hFF);

      // Contention: both held continuously from relative cycle 0
      A0 = 8'h10; B0 = 8'h20; CIN0 = 1'b1;
      A1 = 8'h80; B1 = 8'h80; CIN1 = 1'b0;
      REQ0 = 1'b1; REQ1 = 1'b1;
      for (int i = 1; i <= 22; i++) begin
         step();
`ifdef ADDER_ARB_FIXED_PRIO_EN
         e0 = (i % 4 == 3);
         e1 = 1'b0;
`else
         e0 = (i == 3) || (i == 11) || (i == 19);
         e1 = (i == 7) || (i == 15);
`endif
         chk($sformatf("cont%0d_ack0", i), 32'(ACK0), 32'(e0));
         chk($sformatf("cont%0d_ack1", i), 32'(ACK1), 32'(e1));
         if (e0) chk($sformatf("cont%0d_q0", i), 32'({Q0, RCO0}), {23'd0, 8'h31, 1'b0});
         if (e1) chk($sformatf("cont%0d_q1", i), 32'({Q1, RCO1}), {23'd0, 8'h00, 1'b1});
      end

      // Relative cycle 22 is a WAIT cycle; abort it
      RESET = 1'b1;
      step();
      chk("mid_rst_out", 32'({GNT, U_EN, ACK1, ACK0}), 32'h0);
      chk("mid_rst_q", 32'({Q1, Q0, RCO1, RCO0}), 32'h0);
      chk("mid_rst_ua", 32'({U_A, U_B, U_CIN, U_MODO}), 32'h0);
      RESET = 1'b0;
      step();
      chk("post_rst_gnt", 32'(GNT), 32'h1);
      chk("post_rst_uen", 32'(U_EN), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
